// File: rtl/reg_bank_wr_decode.sv
// 8-entry register bank with a one-hot write decoder, two bypassed read ports,
// a sticky per-entry valid bitmap and an accepted-write counter.
module reg_bank_wr_decode #(
  parameter int unsigned WIDTH   = 16,
  parameter bit          ZERO_R0 = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [2:0]       wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic [2:0]       rd_addr_a_i,
  input  logic [2:0]       rd_addr_b_i,
  output logic [WIDTH-1:0] rd_data_a_o,
  output logic [WIDTH-1:0] rd_data_b_o,
  output logic [7:0]       valid_map_o,
  output logic             wr_done_o,
  output logic [7:0]       wr_count_o
);

  localparam logic [7:0] R0Mask = ZERO_R0 ? 8'h01 : 8'h00;

  logic [7:0]       dec;
  logic [7:0]       wr_sel;
  logic             wr_accept;
  logic [WIDTH-1:0] mem_q [8];
  logic [WIDTH-1:0] mem_d [8];
  logic [7:0]       valid_q, valid_d;
  logic             done_q, done_d;
  logic [7:0]       count_q, count_d;
  logic [2:0]       rd_addr [2];
  logic [WIDTH-1:0] rd_data [2];

  // Gating by rst_n keeps a write presented during reset from bypassing or landing.
  always_comb begin
    dec = '0;
    if (wr_en_i) dec[wr_addr_i] = 1'b1;
    wr_sel    = rst_n ? (dec & ~R0Mask) : 8'h00;
    wr_accept = |wr_sel;
  end

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      mem_d[i] = wr_sel[i] ? wr_data_i : mem_q[i];
    end
    valid_d = valid_q | wr_sel;
    done_d  = wr_accept;
    count_d = count_q + {7'd0, wr_accept};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        mem_q[i] <= '0;
      end
      valid_q <= R0Mask;
      done_q  <= 1'b0;
      count_q <= 8'h00;
    end else begin
      for (int i = 0; i < 8; i++) begin
        mem_q[i] <= mem_d[i];
      end
      valid_q <= valid_d;
      done_q  <= done_d;
      count_q <= count_d;
    end
  end

  assign rd_addr[0] = rd_addr_a_i;
  assign rd_addr[1] = rd_addr_b_i;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = mem_q[rd_addr[p]];
      if (wr_accept && (wr_addr_i == rd_addr[p])) rd_data[p] = wr_data_i;
      if (ZERO_R0 && (rd_addr[p] == 3'd0)) rd_data[p] = '0;
    end
  end

  assign rd_data_a_o = rd_data[0];
  assign rd_data_b_o = rd_data[1];
  assign valid_map_o = valid_q;
  assign wr_done_o   = done_q;
  assign wr_count_o  = count_q;

endmodule

// File: tb/tb_reg_bank_wr_decode.sv
// Bench for reg_bank_wr_decode: one instance with ZERO_R0=1 and one with ZERO_R0=0
// share stimulus; both are checked against an array-based reference model.
module tb_reg_bank_wr_decode;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [2:0]  addr, ra, rb;
  logic [15:0] data;

  logic [15:0] rd_a_z, rd_b_z, rd_a_p, rd_b_p;
  logic [7:0]  vm_z, vm_p, cnt_z, cnt_p;
  logic        done_z, done_p;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_bank_wr_decode #(.WIDTH(16), .ZERO_R0(1'b1)) u_z (
    .clk(clk), .rst_n(rst_n), .wr_en_i(en), .wr_addr_i(addr), .wr_data_i(data),
    .rd_addr_a_i(ra), .rd_addr_b_i(rb), .rd_data_a_o(rd_a_z), .rd_data_b_o(rd_b_z),
    .valid_map_o(vm_z), .wr_done_o(done_z), .wr_count_o(cnt_z)
  );

  reg_bank_wr_decode #(.WIDTH(16), .ZERO_R0(1'b0)) u_p (
    .clk(clk), .rst_n(rst_n), .wr_en_i(en), .wr_addr_i(addr), .wr_data_i(data),
    .rd_addr_a_i(ra), .rd_addr_b_i(rb), .rd_data_a_o(rd_a_p), .rd_data_b_o(rd_b_p),
    .valid_map_o(vm_p), .wr_done_o(done_p), .wr_count_o(cnt_p)
  );

  // Reference model; index 0 models the ZERO_R0=1 instance, index 1 the plain one.
  logic [15:0] m   [2][8];
  logic [7:0]  mv  [2];
  logic [7:0]  mc  [2];
  logic        md  [2];

  function automatic logic acc(int d);
    return rst_n && en && !(d == 0 && addr == 3'd0);
  endfunction

  function automatic logic [15:0] exp_rd(int d, logic [2:0] r);
    if (d == 0 && r == 3'd0) return 16'h0000;
    if (acc(d) && addr == r) return data;
    return m[d][r];
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 8; i++) m[d][i] = 16'h0000;
      mv[d] = (d == 0) ? 8'h01 : 8'h00;
      mc[d] = 8'h00;
      md[d] = 1'b0;
    end
  endtask

  task automatic model_edge();
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        md[d] = acc(d);
        if (acc(d)) begin
          m[d][addr]  = data;
          mv[d][addr] = 1'b1;
          mc[d]       = mc[d] + 8'd1;
        end
      end
    end
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_reads();
    chk("rd_a_z", {16'd0, rd_a_z}, {16'd0, exp_rd(0, ra)});
    chk("rd_b_z", {16'd0, rd_b_z}, {16'd0, exp_rd(0, rb)});
    chk("rd_a_p", {16'd0, rd_a_p}, {16'd0, exp_rd(1, ra)});
    chk("rd_b_p", {16'd0, rd_b_p}, {16'd0, exp_rd(1, rb)});
  endtask

  task automatic check_regs();
    chk("valid_z", {24'd0, vm_z}, {24'd0, mv[0]});
    chk("count_z", {24'd0, cnt_z}, {24'd0, mc[0]});
    chk("done_z", {31'd0, done_z}, {31'd0, md[0]});
    chk("valid_p", {24'd0, vm_p}, {24'd0, mv[1]});
    chk("count_p", {24'd0, cnt_p}, {24'd0, mc[1]});
    chk("done_p", {31'd0, done_p}, {31'd0, md[1]});
  endtask

  task automatic step(input logic e, input logic [2:0] a, input logic [15:0] dt,
                      input logic [2:0] xa, input logic [2:0] xb);
    en = e; addr = a; data = dt; ra = xa; rb = xb;
    #1 check_reads();
    @(posedge clk);
    model_edge();
    #1 check_regs();
  endtask

  typedef struct {
    logic        en;
    logic [2:0]  a;
    logic [15:0] d;
    logic [2:0]  ra, rb;
    logic [15:0] ea, eb;
    logic        done;
    logic [7:0]  cnt, vm;
  } vec_t;

  vec_t tbl[5];
  logic [7:0] cnt_save;

  initial begin
    // Expectations for the ZERO_R0=1 instance, straight after reset.
    tbl[0] = '{1'b1, 3'd3, 16'hA5A5, 3'd3, 3'd1, 16'hA5A5, 16'h0000, 1'b1, 8'd1, 8'h09};
    tbl[1] = '{1'b0, 3'd3, 16'h0000, 3'd3, 3'd2, 16'hA5A5, 16'h0000, 1'b0, 8'd1, 8'h09};
    tbl[2] = '{1'b1, 3'd5, 16'h1234, 3'd5, 3'd5, 16'h1234, 16'h1234, 1'b1, 8'd2, 8'h29};
    tbl[3] = '{1'b1, 3'd0, 16'hFFFF, 3'd0, 3'd5, 16'h0000, 16'h1234, 1'b0, 8'd2, 8'h29};
    tbl[4] = '{1'b0, 3'd0, 16'h0000, 3'd0, 3'd3, 16'h0000, 16'hA5A5, 1'b0, 8'd2, 8'h29};

    rst_n = 1'b0; en = 1'b0; addr = 3'd0; data = 16'h0; ra = 3'd0; rb = 3'd0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset state: every entry reads 0 on both ports.
    chk("rst_valid", {24'd0, vm_z}, 32'h01);
    chk("rst_count", {24'd0, cnt_z}, 32'h00);
    for (int i = 0; i < 8; i++) step(1'b0, 3'd0, 16'h0, i[2:0], 3'(7 - i));

    for (int i = 0; i < 5; i++) begin
      en = tbl[i].en; addr = tbl[i].a; data = tbl[i].d; ra = tbl[i].ra; rb = tbl[i].rb;
      #1;
      chk($sformatf("tbl%0d_rd_a", i), {16'd0, rd_a_z}, {16'd0, tbl[i].ea});
      chk($sformatf("tbl%0d_rd_b", i), {16'd0, rd_b_z}, {16'd0, tbl[i].eb});
      check_reads();
      @(posedge clk);
      model_edge();
      #1;
      chk($sformatf("tbl%0d_done", i), {31'd0, done_z}, {31'd0, tbl[i].done});
      chk($sformatf("tbl%0d_count", i), {24'd0, cnt_z}, {24'd0, tbl[i].cnt});
      chk($sformatf("tbl%0d_valid", i), {24'd0, vm_z}, {24'd0, tbl[i].vm});
      check_regs();
    end
    // The plain instance accepted the write to entry 0.
    chk("r0_plain", {16'd0, rd_a_p}, 32'hFFFF);
    chk("r0_plain_cnt", {24'd0, cnt_p}, 32'd3);

    // 256 back-to-back writes over entries 1..7: counter wraps, wr_done stays high.
    cnt_save = mc[0];
    for (int i = 0; i < 256; i++) begin
      step(1'b1, 3'(1 + (i % 7)), 16'($urandom), 3'($urandom_range(0, 7)),
           3'($urandom_range(0, 7)));
      chk("b2b_done", {31'd0, done_z}, 32'd1);
    end
    chk("wrap_count", {24'd0, cnt_z}, {24'd0, cnt_save});
    for (int i = 0; i < 8; i++) step(1'b0, 3'($urandom), 16'h0, i[2:0], i[2:0]);

    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), 3'($urandom), 16'($urandom),
           3'($urandom), 3'($urandom));
    end

    // Asynchronous reset between edges while writing entry 6.
    en = 1'b1; addr = 3'd6; data = 16'hBEEF; ra = 3'd6; rb = 3'd6;
    #1 check_reads();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rd", {16'd0, rd_a_z}, 32'h0);
    chk("async_valid", {24'd0, vm_z}, 32'h01);
    chk("async_count", {24'd0, cnt_z}, 32'h0);
    check_reads();
    check_regs();
    @(posedge clk);
    #1 check_regs();
    @(negedge clk);
    rst_n = 1'b1; en = 1'b0;
    #1;
    chk("post_rst_e6", {16'd0, rd_a_z}, 32'h0);
    chk("post_rst_valid", {24'd0, vm_z}, 32'h01);
    check_reads();
    // First edge after release accepts a write with no warm-up.
    step(1'b1, 3'd6, 16'h5A5A, 3'd6, 3'd0);
    chk("first_wr_count", {24'd0, cnt_z}, 32'd1);
    step(1'b0, 3'd0, 16'h0, 3'd6, 3'd6);
    chk("first_wr_e6", {16'd0, rd_a_z}, 32'h5A5A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
